// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan job controller.
package pattern_scan_pkg;

    // Width of the serial pattern being searched for.
    localparam int PAT_W = 3;

    // Controller states; encodings are fixed so waveforms are easy to read.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        SHIFT = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Five-character ASCII state name for waveform viewing.
    function automatic logic [39:0] state_name(input state_t s);
        case (s)
            IDLE:    state_name = "IDLE ";
            WAIT:    state_name = "WAIT ";
            SHIFT:   state_name = "SHIFT";
            FLUSH:   state_name = "FLUSH";
            DONE:    state_name = "DONE ";
            default: state_name = "?????";
        endcase
    endfunction

endpackage

// File: rtl/pattern_scan_ctrl_seq_detect.sv
// Bit-serial 3-bit overlapping pattern detector with a registered match strobe.
module seq_detect3
    import pattern_scan_pkg::*;
(
    input  logic             clk,
    input  logic             _rst,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pat,
    output logic             match
);

    // Only the two most recent bits need storing: the third bit of the
    // compared window is always the bit arriving this cycle.
    logic [PAT_W-2:0] hist;
    logic [1:0]       fill;
    logic [PAT_W-1:0] window;

    assign window = {hist, bit_in};

    // Shift history on each fed bit; match only once two earlier bits exist.
    always_ff @(posedge clk) begin
        if (!_rst || clr) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else if (bit_vld) begin
            hist  <= window[PAT_W-2:0];
            if (fill != 2'd3)
                fill <= fill + 2'd1;
            match <= (fill >= 2'd2) && (window == pat);
        end else begin
            match <= 1'b0;
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Job controller: takes a pattern and word count, serializes incoming words
// MSB first into the detector and reports a saturating match total.
module pattern_scan_ctrl
    import pattern_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int NW_W   = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic              start,
    input  logic [PAT_W-1:0]  cfg_pat,
    input  logic [NW_W-1:0]   cfg_words,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              match_bit
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [39:0]       txstate;
    logic [WORD_W-1:0] sreg;
    logic [BIT_W-1:0]  bitcnt;
    logic [NW_W-1:0]   words_left;
    logic [PAT_W-1:0]  cfg_pat_q;
    logic              job_start;
    logic              bit_vld;

    assign job_start = (state == IDLE) && start;
    assign bit_vld   = (state == SHIFT);

    // Next-state decision; shared by the state register and the registered outputs.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (cfg_words != '0) ? WAIT : FLUSH;
            WAIT:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (bitcnt == '0) state_nxt = (words_left == NW_W'(1)) ? FLUSH : WAIT;
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, serializer, job counters, match counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!_rst) begin
            state      <= IDLE;
            txstate    <= state_name(IDLE);
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match_cnt  <= '0;
            sreg       <= '0;
            bitcnt     <= '0;
            words_left <= '0;
            cfg_pat_q  <= '0;
        end else begin
            state    <= state_nxt;
            txstate  <= state_name(state_nxt);
            in_ready <= (state_nxt == WAIT);
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);

            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_pat_q  <= cfg_pat;
                        words_left <= cfg_words;
                    end
                end
                WAIT: begin
                    if (in_valid) begin
                        sreg   <= in_data;
                        bitcnt <= BIT_W'(WORD_W - 1);
                    end
                end
                SHIFT: begin
                    sreg   <= {sreg[WORD_W-2:0], 1'b0};
                    bitcnt <= bitcnt - BIT_W'(1);
                    if (bitcnt == '0)
                        words_left <= words_left - NW_W'(1);
                end
                default: begin
                end
            endcase

            if (job_start)
                match_cnt <= '0;
            else if (match_bit && (match_cnt != CNT_MAX))
                match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    seq_detect3 u_detect (
        .clk     (clk),
        ._rst    (_rst),
        .clr     (job_start),
        .bit_vld (bit_vld),
        .bit_in  (sreg[WORD_W-1]),
        .pat     (cfg_pat_q),
        .match   (match_bit)
    );

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed self-checking bench for pattern_scan_ctrl.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       _rst;
    logic       start;
    logic [2:0] cfg_pat;
    logic [3:0] cfg_words;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [3:0] match_cnt;
    logic       match_bit;

    int checks = 0;
    int errors = 0;
    logic [7:0] words [0:3];

    pattern_scan_ctrl #(.WORD_W(8), .NW_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        ._rst      (_rst),
        .start     (start),
        .cfg_pat   (cfg_pat),
        .cfg_words (cfg_words),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .match_bit (match_bit)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Run one job from IDLE; called #1 after a clock edge. Words come from 'words'.
    // gap: cycles in_valid is held low in WAIT before the second word.
    // midStart: pulse start with different cfg during SHIFT.
    task automatic applyStimulus(input string tag, input logic [2:0] pat, input int n,
                                 input int gap, input bit midStart, input int expCnt,
                                 input int expDone, input int expMb);
        int cyc, idx, gapUsed, doneCyc, busyCyc, readyCyc, mbCyc, cnt;
        bit acc, holdGap;
        cfg_pat   = pat;
        cfg_words = 4'(n);
        start     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'hFF;
        idx = 0; gapUsed = 0; doneCyc = -1; busyCyc = 0; readyCyc = 0; mbCyc = 0; cnt = -1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 300 && doneCyc < 0) begin
            if (busy)      busyCyc++;
            if (in_ready)  readyCyc++;
            if (match_bit) mbCyc++;
            if (done) begin
                doneCyc = cyc;
                cnt = int'(match_cnt);
            end else begin
                holdGap = (idx == 1) && (gapUsed < gap) && in_ready;
                if (idx < n && !holdGap) begin
                    in_valid = 1'b1;
                    in_data  = words[idx];
                end else begin
                    in_valid = 1'b0;
                    in_data  = 8'hFF;
                    if (holdGap) gapUsed++;
                end
                acc = in_valid && in_ready;
                if (midStart && cyc == 4) begin
                    start     = 1'b1;
                    cfg_pat   = ~pat;
                    cfg_words = 4'd7;
                end
                @(posedge clk); #1;
                start = 1'b0;
                cyc++;
                if (acc) idx++;
            end
        end
        in_valid = 1'b0;
        checkOutput({tag, "_done_cycle"}, doneCyc, expDone);
        checkOutput({tag, "_match_cnt"}, cnt, expCnt);
        checkOutput({tag, "_busy_cycles"}, busyCyc, expDone);
        checkOutput({tag, "_ready_cycles"}, readyCyc, n + gap);
        checkOutput({tag, "_match_pulses"}, mbCyc, expMb);
        @(posedge clk); #1;
        checkOutput({tag, "_post_busy"}, int'(busy), 0);
        checkOutput({tag, "_post_done"}, int'(done), 0);
        checkOutput({tag, "_post_cnt_hold"}, int'(match_cnt), expCnt);
    endtask

    initial begin
        int doneSeen;
        _rst = 1'b0; start = 1'b0; cfg_pat = '0; cfg_words = '0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_ready", int'(in_ready), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_cnt", int'(match_cnt), 0);
        checkOutput("rst_mb", int'(match_bit), 0);
        _rst = 1'b1;
        @(posedge clk); #1;

        // 0,1,0,1,0,1,0,0 -> three overlapping 010 windows.
        words[0] = 8'b0101_0100;
        applyStimulus("t1", 3'b010, 1, 0, 1'b0, 3, 11, 3);

        // 010 only across the boundary of 00000001 | 00000000.
        words[0] = 8'h01; words[1] = 8'h00;
        applyStimulus("t2", 3'b010, 2, 0, 1'b0, 1, 20, 1);

        // 24 zeros: 22 raw matches, counter saturates at 15.
        words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
        applyStimulus("t3", 3'b000, 3, 0, 1'b0, 15, 29, 22);

        // 10100101 01011010 holds five 101 windows; gap delays done by 5.
        words[0] = 8'hA5; words[1] = 8'h5A;
        applyStimulus("t4_nogap", 3'b101, 2, 0, 1'b0, 5, 20, 5);
        applyStimulus("t4_gap", 3'b101, 2, 5, 1'b0, 5, 25, 5);

        // Start during SHIFT is ignored.
        words[0] = 8'b0101_0100;
        applyStimulus("t5_midstart", 3'b010, 1, 0, 1'b1, 3, 11, 3);

        // Empty job.
        applyStimulus("t5_zero", 3'b010, 0, 0, 1'b0, 0, 2, 0);

        // Reset mid-SHIFT abandons the job.
        cfg_pat = 3'b010; cfg_words = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'b0101_0100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        _rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_busy", int'(busy), 0);
        checkOutput("t6_ready", int'(in_ready), 0);
        checkOutput("t6_done", int'(done), 0);
        checkOutput("t6_cnt", int'(match_cnt), 0);
        checkOutput("t6_mb", int'(match_bit), 0);
        _rst = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("t6_no_done", doneSeen, 0);

        // Fresh job after reset.
        words[0] = 8'hA5; words[1] = 8'h5A;
        applyStimulus("t6_after", 3'b101, 2, 0, 1'b0, 5, 20, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
